// File: rtl/spi_reg_master.sv
// rtl/spi_reg_master.sv - SPI mode-0 register-access master, one 16-bit frame per transaction
//
// Purpose: sends {rw, addr[6:0]} followed by wr_data (write) or 8'h00 (read)
// under a single chip-select low period. For a read, the second received byte
// is returned on rd_data.
//
// Ports:
//   clk, reset_n             single rising-edge clock, synchronous active-low reset
//   start, rw, addr, wr_data transaction request and its fields, captured together
//   busy, done, rd_data      status, one-cycle completion pulse, last read byte
//   spi_cs0, spi_clk         chip select (active low), SPI clock (idles low)
//   spi_mosi, spi_miso       serial data out / in, MSB first
module spi_reg_master #(
    parameter int CLK_DIV = 4,
    parameter int CS_GAP  = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       rw,
    input  logic [6:0] addr,
    input  logic [7:0] wr_data,
    output logic       busy,
    output logic       done,
    output logic [7:0] rd_data,
    output logic       spi_cs0,
    output logic       spi_clk,
    output logic       spi_mosi,
    input  logic       spi_miso
);

    // One counter times every phase: CS setup/hold and spi_clk half-periods
    // (CLK_DIV) as well as the inter-frame gap (CS_GAP).
    localparam int CNT_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((CS_GAP > 0) ? CS_GAP - 1 : 0);

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        SHIFT,
        CS_HOLD,
        GAP
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [CNT_W-1:0]  cnt;
    logic [4:0]        edge_cnt;
    logic [15:0]       tx_shift;
    logic [7:0]        rx_shift;
    logic              rw_q;
    logic              div_last;
    logic              gap_last;
    logic              last_edge;

    assign div_last  = (cnt == DIV_LAST);
    assign gap_last  = (cnt == GAP_LAST);
    // edge_cnt counts spi_clk toggles within SHIFT; toggle 31 is the 16th falling edge.
    assign last_edge = (edge_cnt == 5'd31);

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = CS_SETUP;
                end
            end
            CS_SETUP: begin
                if (div_last) begin
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                if (div_last && last_edge) begin
                    state_n = CS_HOLD;
                end
            end
            CS_HOLD: begin
                if (div_last) begin
                    state_n = (CS_GAP == 0) ? IDLE : GAP;
                end
            end
            GAP: begin
                if (gap_last) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        busy     = 1'b0;
        spi_cs0  = 1'b1;
        spi_mosi = 1'b0;
        if (state != IDLE) begin
            busy = 1'b1;
        end
        if (state == CS_SETUP || state == SHIFT || state == CS_HOLD) begin
            spi_cs0  = 1'b0;
            spi_mosi = tx_shift[15];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= '0;
            edge_cnt <= 5'd0;
            tx_shift <= 16'h0000;
            rx_shift <= 8'h00;
            rw_q     <= 1'b0;
            spi_clk  <= 1'b0;
            done     <= 1'b0;
            rd_data  <= 8'h00;
        end else begin
            state <= state_n;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    cnt      <= '0;
                    edge_cnt <= 5'd0;
                    spi_clk  <= 1'b0;
                    if (start) begin
                        rw_q     <= rw;
                        tx_shift <= {rw, addr, (rw ? 8'h00 : wr_data)};
                    end
                end
                CS_SETUP: begin
                    cnt <= div_last ? '0 : cnt + CNT_W'(1);
                end
                SHIFT: begin
                    if (div_last) begin
                        cnt     <= '0;
                        spi_clk <= ~spi_clk;
                        if (!last_edge) begin
                            edge_cnt <= edge_cnt + 5'd1;
                        end
                        if (!spi_clk) begin
                            // rising edge: sample; only the last 8 bits survive
                            rx_shift <= {rx_shift[6:0], spi_miso};
                        end else if (!last_edge) begin
                            // falling edge: present next bit; the final bit stays through CS_HOLD
                            tx_shift <= {tx_shift[14:0], 1'b0};
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                CS_HOLD: begin
                    if (div_last) begin
                        cnt  <= '0;
                        done <= 1'b1;
                        if (rw_q) begin
                            rd_data <= rx_shift;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                GAP: begin
                    cnt <= gap_last ? '0 : cnt + CNT_W'(1);
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_reg_master.sv
// tb/tb_spi_reg_master.sv - self-checking bench for spi_reg_master with a frame-level reference model
module tb_spi_reg_master;

    localparam int CD = 4;
    localparam int CG = 2;
    localparam int L  = 34 * CD;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n, start, rw;
    logic [6:0] addr;
    logic [7:0] wr_data;
    logic       busy, done, spi_cs0, spi_clk, spi_mosi, spi_miso;
    logic [7:0] rd_data;

    logic       start2, rw2;
    logic [6:0] addr2;
    logic [7:0] wr_data2;
    logic       busy2, done2, spi_cs0_2, spi_clk2, spi_mosi2, spi_miso2;
    logic [7:0] rd_data2;

    spi_reg_master #(.CLK_DIV(CD), .CS_GAP(CG)) u_dut (
        .clk(clk), .reset_n(reset_n), .start(start), .rw(rw), .addr(addr),
        .wr_data(wr_data), .busy(busy), .done(done), .rd_data(rd_data),
        .spi_cs0(spi_cs0), .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
    );

    spi_reg_master #(.CLK_DIV(2), .CS_GAP(CG)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .start(start2), .rw(rw2), .addr(addr2),
        .wr_data(wr_data2), .busy(busy2), .done(done2), .rd_data(rd_data2),
        .spi_cs0(spi_cs0_2), .spi_clk(spi_clk2), .spi_mosi(spi_mosi2), .spi_miso(spi_miso2)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Slave models: load a 16-bit reply at CS fall, advance on each spi_clk fall.
    logic [15:0] miso_frame = 16'h0000, sframe = 16'h0000;
    int          sidx = 16;
    always @(negedge spi_cs0) begin sframe = miso_frame; sidx = 0; end
    always @(negedge spi_clk) if (spi_cs0 == 1'b0 && sidx < 16) sidx++;
    assign spi_miso = (sidx < 16) ? sframe[15 - sidx] : 1'b0;

    logic [15:0] miso_frame2 = 16'h0000, sframe2 = 16'h0000;
    int          sidx2 = 16;
    always @(negedge spi_cs0_2) begin sframe2 = miso_frame2; sidx2 = 0; end
    always @(negedge spi_clk2) if (spi_cs0_2 == 1'b0 && sidx2 < 16) sidx2++;
    assign spi_miso2 = (sidx2 < 16) ? sframe2[15 - sidx2] : 1'b0;

    // Monitors: MOSI captured on spi_clk rising edges, pulse and done counts.
    logic [15:0] cap = 16'h0000, cap2 = 16'h0000;
    int pulses = 0, pulses2 = 0, done_cnt = 0, done_cnt2 = 0;
    int cyc = 0, last_rise2 = -1, period2 = 0;
    always @(posedge spi_clk)  begin cap  = {cap[14:0], spi_mosi};   pulses++;  end
    always @(posedge spi_clk2) begin
        cap2 = {cap2[14:0], spi_mosi2};
        pulses2++;
        if (last_rise2 >= 0) period2 = cyc - last_rise2;
        last_rise2 = cyc;
    end
    always @(posedge clk) cyc++;
    always @(negedge clk) begin
        if (done === 1'b1)  done_cnt++;
        if (done2 === 1'b1) done_cnt2++;
    end

    task automatic clear_mon();
        cap = 16'h0000; pulses = 0; done_cnt = 0;
    endtask

    // Reference model: t = cycles since the accepting edge; everything else
    // follows from the frame layout and phase lengths.
    int          t = -1;
    logic        m_rw = 1'b0;
    logic [15:0] m_mosi = 16'h0000, m_miso = 16'h0000;
    logic [7:0]  exp_rd = 8'h00;
    bit          model_on = 1'b0;

    function automatic bit m_idle();
        return (t < 0 || t > L + CG);
    endfunction

    always @(posedge clk) begin
        if (reset_n !== 1'b1) begin
            t = -1; exp_rd = 8'h00; model_on = 1'b1;
        end else if (m_idle()) begin
            if (start === 1'b1) begin
                t = 1; m_rw = rw; m_miso = miso_frame;
                m_mosi = {rw, addr, (rw ? 8'h00 : wr_data)};
            end
        end else begin
            t++;
            if (t == L + 1 && m_rw) exp_rd = m_miso[7:0];
        end
    end

    always @(negedge clk) begin
        logic e_busy, e_cs, e_clk, e_mosi, e_done;
        int   h, b;
        if (model_on) begin
            e_busy = 1'b0; e_cs = 1'b1; e_clk = 1'b0; e_mosi = 1'b0; e_done = 1'b0;
            if (!m_idle()) begin
                e_busy = 1'b1;
                if (t <= L) begin
                    e_cs = 1'b0;
                    if (t <= CD) b = 15;
                    else if (t <= 33 * CD) begin
                        h = (t - CD - 1) / CD;
                        e_clk = ((h % 2) == 1);
                        b = 15 - h / 2;
                    end else b = 0;
                    e_mosi = m_mosi[b];
                end
                e_done = (t == L + 1);
            end
            check("m_busy", busy, e_busy);
            check("m_cs0", spi_cs0, e_cs);
            check("m_sclk", spi_clk, e_clk);
            check("m_mosi", spi_mosi, e_mosi);
            check("m_done", done, e_done);
            check("m_rd_data", rd_data, exp_rd);
        end
    end

    task automatic send1(input logic r, input logic [6:0] a, input logic [7:0] d);
        start = 1'b1; rw = r; addr = a; wr_data = d;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done1(input string name);
        int i;
        for (i = 0; i < 400; i++) begin
            @(negedge clk);
            if (done === 1'b1) break;
        end
        check({name, "_done_seen"}, (i < 400), 1);
    endtask

    task automatic wait_idle1(input string name);
        int i;
        for (i = 0; i < 50; i++) begin
            if (busy === 1'b0) break;
            @(negedge clk);
        end
        check({name, "_idle_seen"}, (i < 50), 1);
    endtask

    initial begin
        int n, rst_at, c;
        reset_n = 1'b0; start = 1'b0; rw = 1'b0; addr = 7'h00; wr_data = 8'h00;
        start2 = 1'b0; rw2 = 1'b0; addr2 = 7'h00; wr_data2 = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_cs0", spi_cs0, 1'b1);
        check("rst_sclk", spi_clk, 1'b0);
        check("rst_mosi", spi_mosi, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_rd_data", rd_data, 8'h00);
        check("rst_rd_data2", rd_data2, 8'h00);
        reset_n = 1'b1;
        @(negedge clk);

        // Read 0x10; slave replies FF then 3C.
        miso_frame = 16'hFF3C; clear_mon();
        send1(1'b1, 7'h10, 8'hAA);
        wait_done1("rd");
        check("rd_rd_data_at_done", rd_data, 8'h3C);
        n = 0;
        while (busy === 1'b1 && n < 20) begin n++; @(negedge clk); end
        check("rd_busy_after_done", n, CG);
        check("rd_byte0", cap[15:8], 8'h90);
        check("rd_byte1", cap[7:0], 8'h00);
        check("rd_pulses", pulses, 16);
        check("rd_done_cnt", done_cnt, 1);

        // Write 0x11 <- A5.
        miso_frame = 16'h1234; clear_mon();
        send1(1'b0, 7'h11, 8'hA5);
        wait_done1("wr");
        wait_idle1("wr");
        check("wr_frame", cap, 16'h11A5);
        check("wr_pulses", pulses, 16);
        check("wr_done_cnt", done_cnt, 1);
        check("wr_rd_data_kept", rd_data, 8'h3C);

        // Start pulsed 10 cycles into SHIFT with a different address.
        clear_mon();
        send1(1'b0, 7'h22, 8'h77);
        repeat (CD + 9) @(negedge clk);
        start = 1'b1; rw = 1'b1; addr = 7'h55; wr_data = 8'h00;
        @(negedge clk);
        start = 1'b0;
        wait_done1("ign");
        wait_idle1("ign");
        check("ign_frame", cap, 16'h2277);
        check("ign_done_cnt", done_cnt, 1);
        check("ign_rd_data_kept", rd_data, 8'h3C);

        // Reset after the 5th rising edge of a read, with start high in the reset cycle.
        miso_frame = 16'hABCD; clear_mon();
        send1(1'b1, 7'h33, 8'h00);
        for (c = 0; c < 300; c++) begin
            if (pulses >= 5) break;
            @(negedge clk);
        end
        check("abort_5th_edge_seen", (c < 300), 1);
        reset_n = 1'b0; start = 1'b1; rw = 1'b0; addr = 7'h06;
        @(negedge clk);
        check("abort_cs0", spi_cs0, 1'b1);
        check("abort_sclk", spi_clk, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_rd_data", rd_data, 8'h00);
        reset_n = 1'b1; start = 1'b0;
        @(negedge clk);
        check("abort_start_ignored", busy, 1'b0);
        repeat (3) @(negedge clk);
        check("abort_no_done", done_cnt, 0);
        clear_mon();
        send1(1'b0, 7'h06, 8'h5A);
        wait_done1("post");
        wait_idle1("post");
        check("post_frame", cap, 16'h065A);
        check("post_pulses", pulses, 16);
        check("post_done_cnt", done_cnt, 1);
        check("post_rd_data", rd_data, 8'h00);

        // Start held high: two back-to-back writes.
        clear_mon();
        start = 1'b1; rw = 1'b0; addr = 7'h4B; wr_data = 8'hC3;
        wait_done1("b2b1");
        n = 0;
        while (spi_cs0 === 1'b1 && n < 50) begin n++; @(negedge clk); end
        check("b2b_cs_high", n, CG + 1);
        start = 1'b0;
        wait_done1("b2b2");
        wait_idle1("b2b");
        check("b2b_done_cnt", done_cnt, 2);
        check("b2b_pulses", pulses, 32);
        check("b2b_frame", cap, 16'h4BC3);

        // CLK_DIV = 2 read.
        miso_frame2 = 16'h5AE7; cap2 = 16'h0000; pulses2 = 0; last_rise2 = -1; done_cnt2 = 0;
        start2 = 1'b1; rw2 = 1'b1; addr2 = 7'h2A; wr_data2 = 8'h11;
        @(negedge clk);
        start2 = 1'b0;
        for (c = 0; c < 200; c++) begin
            @(negedge clk);
            if (busy2 === 1'b0) break;
        end
        check("div2_idle_seen", (c < 200), 1);
        check("div2_rd_data", rd_data2, 8'hE7);
        check("div2_period", period2, 4);
        check("div2_pulses", pulses2, 16);
        check("div2_frame", cap2, 16'hAA00);
        check("div2_done_cnt", done_cnt2, 1);

        // Randomized traffic with stray starts and occasional mid-frame resets.
        for (int it = 0; it < 40; it++) begin
            miso_frame = 16'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            rst_at = ($urandom_range(0, 5) == 0) ? int'($urandom_range(2, 140)) : -1;
            send1(1'($urandom_range(0, 1)), 7'($urandom), 8'($urandom));
            for (c = 0; c < 300; c++) begin
                reset_n = (c == rst_at) ? 1'b0 : 1'b1;
                start = (busy === 1'b1 && $urandom_range(0, 15) == 0);
                if (start) begin
                    rw = 1'($urandom_range(0, 1)); addr = 7'($urandom); wr_data = 8'($urandom);
                end
                @(negedge clk);
                start = 1'b0; reset_n = 1'b1;
                if (busy === 1'b0) break;
            end
            check("rand_finished", (c < 300), 1);
        end

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, %0d tests run, %0d failed", tests, fails);
        $fatal(1);
    end

endmodule

// File: doc/spi_reg_master.md
SPI_REG_MASTER -- requirements
Module: spi_reg_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: clk cycles per spi_clk half-period; legal values are integers of 2 or more.
REQ-002 SHALL have parameter CS_GAP, default 2: idle clk cycles with spi_cs0 high after each transaction.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port start, input, 1 bit: transaction request, sampled only while busy=0.
REQ-006 SHALL have port rw, input, 1 bit: 1 = register read, 0 = register write; captured with start.
REQ-007 SHALL have port addr, input, 7 bits: register address; captured with start.
REQ-008 SHALL have port wr_data, input, 8 bits: write data; captured with start.
REQ-009 SHALL have port busy, output, 1 bit: high from the cycle after start acceptance until return to IDLE.
REQ-010 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-011 SHALL have port rd_data, output, 8 bits: data returned by the last read.
REQ-012 SHALL have port spi_cs0, output, 1 bit: chip select, active low.
REQ-013 SHALL have port spi_clk, output, 1 bit: SPI mode 0 clock, idles low.
REQ-014 SHALL have port spi_mosi, output, 1 bit: serial data out, MSB first.
REQ-015 SHALL have port spi_miso, input, 1 bit: serial data in, MSB first.

Function
REQ-016 SHALL frame each transaction as 16 bits under one spi_cs0 low period: byte0 = {rw, addr[6:0]}, then byte1 = wr_data for a write or 8'h00 for a read.
REQ-017 SHALL implement FSM states IDLE -> CS_SETUP -> SHIFT -> CS_HOLD -> GAP -> IDLE.
REQ-018 SHALL, in IDLE with start=1, latch rw, addr and wr_data into a 16-bit shift register, set busy=1 and spi_cs0=0 on the next cycle, and enter CS_SETUP.
REQ-019 SHALL ignore start while busy=1: no capture and no effect on the current transaction.
REQ-020 SHALL hold CS_SETUP for CLK_DIV cycles, with spi_clk=0 and spi_mosi = frame bit 15.
REQ-021 SHALL, in SHIFT, toggle spi_clk every CLK_DIV cycles, producing exactly 16 rising and 16 falling edges, i.e. 32*CLK_DIV cycles.
REQ-022 SHALL sample spi_miso into a receive shift register on each spi_clk rising edge.
REQ-023 SHALL advance spi_mosi to the next bit on each spi_clk falling edge except the 16th; spi_mosi is stable for the whole high half-period.
REQ-024 SHALL, after the 16th falling edge, enter CS_HOLD for CLK_DIV cycles with spi_clk=0 and spi_cs0 still low.
REQ-025 SHALL, on leaving CS_HOLD, set spi_cs0=1, pulse done for exactly one cycle, and enter GAP.
REQ-026 SHALL, for a read, load rd_data with the last 8 sampled bits (bits 7..0) in the same cycle as done; the first 8 sampled bits are discarded.
REQ-027 SHALL leave rd_data unchanged for a write.
REQ-028 SHALL hold GAP for CS_GAP cycles, then clear busy and return to IDLE.
REQ-029 SHALL, if start is held high continuously, begin the next transaction on the first cycle back in IDLE; spi_cs0 is then high for exactly CS_GAP+1 cycles between frames.
REQ-030 SHALL use a divider counter and a 5-bit edge counter, both wide enough for any parameter value; neither wraps within a transaction.

Reset
REQ-031 SHALL, when reset_n=0 on a clk edge, force: FSM=IDLE, spi_cs0=1, spi_clk=0, spi_mosi=0, busy=0, done=0, rd_data=8'h00, and clear all counters.
REQ-032 SHALL, on reset mid-transaction, abort with no done pulse and no rd_data update; the next start after reset_n=1 begins a clean frame.
REQ-033 SHALL ignore start in the same cycle that reset_n=0.

Verification
REQ-034 SHALL cover write: rw=0, addr=7'h11, wr_data=8'hA5, CLK_DIV=4 -> MOSI captured on rising edges = 8'h11 then 8'hA5; exactly 16 spi_clk pulses; one done pulse; rd_data unchanged.
REQ-035 SHALL cover read: rw=1, addr=7'h10, slave model drives 8'h3C in byte1 and 8'hFF in byte0 -> byte0 = 8'h90; rd_data = 8'h3C at done; busy=0 CS_GAP cycles later.
REQ-036 SHALL cover start pulsed 10 cycles into SHIFT with different addr -> ignored; the frame still carries the original address; a single done.
REQ-037 SHALL cover reset_n=0 after the 5th rising edge of a read -> next cycle spi_cs0=1, spi_clk=0, busy=0; no done; rd_data=8'h00; a following write to 7'h06 with 8'h5A completes correctly.
REQ-038 SHALL cover start held high for two writes -> spi_cs0 high for exactly CS_GAP+1=3 cycles between frames; two done pulses.
REQ-039 SHALL cover CLK_DIV=2 read -> spi_clk period of 4 cycles; rd_data correct.
